ntt_mem_arbiter: RTL
====================

NTT_MEM_ARBITER -- requirements
Module: ntt_mem_arbiter

Interface
REQ-001: Parameter NUM_CORES, default 4, number of ntt_engine requesters sharing the memory port.
REQ-002: Parameter ADDR_W, default 48, byte address width.
REQ-003: Parameter DATA_W, default 64, data word width.
REQ-004: Parameter TAG_DEPTH, default 8, maximum outstanding reads (power of 2).
REQ-005: clk  in  1  single clock; all state updates on its rising edge.
REQ-006: rst  in  1  reset, synchronous, active-high.
REQ-007: core_req  in  NUM_CORES  per-core request, held until granted.
REQ-008: core_we  in  NUM_CORES  per-core write enable (1 = write, 0 = read).
REQ-009: core_addr  in  NUM_CORES*ADDR_W  per-core address, core i at bits [i*ADDR_W +: ADDR_W].
REQ-010: core_wdata  in  NUM_CORES*DATA_W  per-core write data, same packing.
REQ-011: core_gnt  out  NUM_CORES  one-hot grant; request accepted in the cycle gnt and req are both high.
REQ-012: core_valid  out  NUM_CORES  one-hot read-response strobe.
REQ-013: core_rdata  out  DATA_W  read data, broadcast to all cores, qualified by core_valid.
REQ-014: mem_req_valid  out  1  memory request valid.
REQ-015: mem_req_ready  in  1  memory accepts a request this cycle.
REQ-016: mem_we / mem_addr / mem_wdata  out  1 / ADDR_W / DATA_W  forwarded fields of the granted core.
REQ-017: mem_rsp_valid  in  1  in-order read response from memory.
REQ-018: mem_rdata  in  DATA_W  read response data.
REQ-019: rsp_err  out  1  sticky flag: response arrived with no outstanding read.
REQ-020: perf_grant_cnt  out  NUM_CORES*32  per-core grant counters (see Configuration).

Function
REQ-021: Grant is combinational from registered state and current inputs; at most one core_gnt bit high per cycle.
REQ-022: Eligible core: core_req high and (core_we high, or tag FIFO count < TAG_DEPTH).
REQ-023: Round-robin selection: search starts at pointer rr_ptr and picks the first eligible core in increasing index order, wrapping from NUM_CORES-1 to 0.
REQ-024: No grant unless mem_req_ready is high; mem_req_valid = OR of core_gnt; mem_we/addr/wdata mux from the granted core, zero when none.
REQ-025: On a grant to core k, rr_ptr <= (k+1) mod NUM_CORES; with no grant, rr_ptr holds.
REQ-026: A granted read pushes k into the tag FIFO in the same cycle; a granted write pushes nothing.
REQ-027: Full check uses the pre-cycle count, so a pop in the same cycle does not unblock a read.
REQ-028: Each mem_rsp_valid pops the FIFO head h; the next cycle has core_valid[h]=1 and core_rdata=mem_rdata (1-cycle registered latency).
REQ-029: Push and pop in the same cycle leave count unchanged; both pointers wrap modulo TAG_DEPTH.
REQ-030: mem_rsp_valid with count == 0: no pop, core_valid stays 0, rsp_err <= 1 until reset.
REQ-031: A core that drops core_req without a grant is legal; no state changes.

Reset
REQ-032: While rst is high: core_gnt = 0 and mem_req_valid = 0 (forced combinationally).
REQ-033: Reset values: core_valid 0, core_rdata 0, rr_ptr 0, FIFO count/pointers 0, rsp_err 0, perf_grant_cnt 0.
REQ-034: Reset mid-operation discards outstanding tags; memory is reset alongside, and any later stray response sets rsp_err per REQ-030.

Configuration
REQ-035: Macro NTT_ARB_PERF_EN defined: perf_grant_cnt[i] increments by 1 on each grant to core i, wrapping at 2^32.
REQ-036: Macro NTT_ARB_PERF_EN undefined: no counter logic; perf_grant_cnt tied to 0.

Verification
REQ-037: Cores 0-3 hold read requests continuously, mem_req_ready=1 -> grant order 0,1,2,3,0; responses return in that order as core_valid 0001,0010,0100,1000.
REQ-038: 8 reads granted with no responses (TAG_DEPTH=8); core 1 read pending, core 2 write pending -> core 2 granted, core 1 blocked; then one response -> core 1 granted the cycle after the pop.
REQ-039: mem_req_ready=0 for 3 cycles with core 3 requesting -> core_gnt=0 and mem_req_valid=0 throughout; ready=1 -> gnt[3]=1, mem_addr=core 3 address.
REQ-040: mem_rsp_valid pulsed with empty FIFO, mem_rdata=0xDEAD -> all core_valid 0, rsp_err=1 stays high until rst.
REQ-041: rst asserted with 4 reads outstanding -> next cycle count 0, rr_ptr 0, core_valid 0; a subsequent core 2 read is granted.
REQ-042: With NTT_ARB_PERF_EN, 5 grants to core 0 and 3 to core 2 -> perf_grant_cnt = {0,3,0,5}; without the macro -> all 0.

Source files
------------

// File: rtl/ntt_mem_arbiter.sv
// ntt_mem_arbiter
//   Shares a single memory request port between NUM_CORES ntt_engine
//   requesters. Requests are granted round-robin, reads are tagged with
//   the requesting core in an in-order tag FIFO, and read responses are
//   steered back to the owning core one cycle after they arrive.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   core_req/we     : per-core request and write enable (held until granted)
//   core_addr/wdata : per-core address / write data, core i at [i*W +: W]
//   core_gnt        : one-hot grant, accepted when gnt & req
//   core_valid      : one-hot read-response strobe
//   core_rdata      : read data broadcast to all cores, qualified by core_valid
//   mem_req_*       : memory request channel (valid/ready, we, addr, wdata)
//   mem_rsp_valid   : in-order read response strobe, data on mem_rdata
//   rsp_err         : sticky, a response arrived with no read outstanding
//   perf_grant_cnt  : per-core 32-bit grant counters, core i at [i*32 +: 32]
//
// Configuration
//   NTT_ARB_PERF_EN : when defined, perf_grant_cnt counts grants per core;
//                     otherwise no counters are built and the port is 0.
//
// TAG_DEPTH must be a power of two (>= 2) so the FIFO pointers wrap freely.

module ntt_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 48,
    parameter int DATA_W    = 64,
    parameter int TAG_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_valid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_rsp_valid,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        rsp_err,
    output logic [NUM_CORES*32-1:0]     perf_grant_cnt
);

    localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W  = TAG_AW + 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(TAG_DEPTH);
    localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(NUM_CORES - 1);

    logic [CORE_W-1:0] rr_ptr;
    logic [CORE_W-1:0] gnt_idx;
    logic              gnt_any;
    logic [CORE_W-1:0] cand;
    int unsigned       pos;

    logic [CORE_W-1:0] tag_mem [TAG_DEPTH];
    logic [TAG_AW-1:0] wr_ptr;
    logic [TAG_AW-1:0] rd_ptr;
    logic [CNT_W-1:0]  tag_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [CORE_W-1:0] head_tag;

    logic [NUM_CORES-1:0] valid_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 err_q;

    assign fifo_full  = (tag_cnt == FULL_CNT);
    assign fifo_empty = (tag_cnt == '0);
    assign head_tag   = tag_mem[rd_ptr];

    // Round-robin search starting at rr_ptr. Full check uses the registered
    // count, so a pop in this same cycle cannot unblock a read.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        pos     = 0;
        for (int unsigned off = 0; off < NUM_CORES; off++) begin
            pos = 32'(rr_ptr) + off;
            if (pos >= unsigned'(NUM_CORES)) begin
                pos = pos - unsigned'(NUM_CORES);
            end
            cand = pos[CORE_W-1:0];
            if (!gnt_any && core_req[cand] && (core_we[cand] || !fifo_full)) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (rst || !mem_req_ready) begin
            gnt_any = 1'b0;
        end
    end

    // Grant decode and request field mux; all zero when nothing is granted.
    always_comb begin
        core_gnt  = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (gnt_any && (gnt_idx == CORE_W'(i))) begin
                core_gnt[i] = 1'b1;
                mem_we      = core_we[i];
                mem_addr    = core_addr[i*ADDR_W +: ADDR_W];
                mem_wdata   = core_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign mem_req_valid = |core_gnt;

    assign push = gnt_any && !mem_we;
    assign pop  = mem_rsp_valid && !fifo_empty;

    // Tag storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
            valid_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (gnt_any) begin
                rr_ptr <= (gnt_idx == LAST_CORE) ? '0 : gnt_idx + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                tag_cnt <= tag_cnt + 1'b1;
            end else if (pop && !push) begin
                tag_cnt <= tag_cnt - 1'b1;
            end
            valid_q <= '0;
            if (pop) begin
                valid_q[head_tag] <= 1'b1;
                rdata_q           <= mem_rdata;
            end
            if (mem_rsp_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign core_valid = valid_q;
    assign core_rdata = rdata_q;
    assign rsp_err    = err_q;

`ifdef NTT_ARB_PERF_EN
    logic [NUM_CORES-1:0][31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (core_gnt[i]) begin
                    perf_q[i] <= perf_q[i] + 32'd1;
                end
            end
        end
    end

    assign perf_grant_cnt = perf_q;
`else
    assign perf_grant_cnt = '0;
`endif

endmodule
